reservation_station: RTL and testbench
======================================

Name: reservation_station

Overview:
Integer-ALU reservation station sitting directly downstream of the dispatcher. It accepts renamed non-memory instructions, holds each until both operands are valid, and snoops both CDBs (ALU and load/store) to resolve operand tags. Each cycle it issues at most one ready instruction to the ALU. It reports fullness upstream so that fetch and dispatch stall.

Parameters:
RS_SIZE, 16, number of entries (power of two).
ROB_ID_WIDTH, 4, ROB tag width; tag 0 means "operand valid, no dependency".
OPENUM_WIDTH, 6, width of the decoded operation enum.
DATA_WIDTH, 32, operand, pc and immediate width.

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
rdy  in  1  global enable; when low, all state and outputs hold
rollback  in  1  misprediction flush from ROB
ena_from_dsp  in  1  dispatch valid
openum_from_dsp  in  OPENUM_WIDTH  operation
V1_from_dsp  in  DATA_WIDTH  operand 1 value
V2_from_dsp  in  DATA_WIDTH  operand 2 value
Q1_from_dsp  in  ROB_ID_WIDTH  operand 1 tag (0 = valid)
Q2_from_dsp  in  ROB_ID_WIDTH  operand 2 tag (0 = valid)
pc_from_dsp  in  DATA_WIDTH  instruction pc
imm_from_dsp  in  DATA_WIDTH  immediate
rob_id_from_dsp  in  ROB_ID_WIDTH  destination ROB tag
valid_from_rs_cdb  in  1  ALU CDB valid
rob_id_from_rs_cdb  in  ROB_ID_WIDTH  ALU CDB tag
result_from_rs_cdb  in  DATA_WIDTH  ALU CDB data
valid_from_ls_cdb  in  1  LSB CDB valid
rob_id_from_ls_cdb  in  ROB_ID_WIDTH  LSB CDB tag
result_from_ls_cdb  in  DATA_WIDTH  LSB CDB data
full_to_if  out  1  stall request (combinational)
ena_to_alu  out  1  issue valid (registered)
openum_to_alu  out  OPENUM_WIDTH  registered
V1_to_alu  out  DATA_WIDTH  registered
V2_to_alu  out  DATA_WIDTH  registered
pc_to_alu  out  DATA_WIDTH  registered
imm_to_alu  out  DATA_WIDTH  registered
rob_id_to_alu  out  ROB_ID_WIDTH  registered

Behaviour:
- Reset (rst=1 at a clk edge): all busy bits cleared; ena_to_alu=0; all other ALU outputs 0. Reset overrides rdy.
- rdy=0: no state change; outputs hold.
- Entry state: busy, openum, V1, V2, Q1, Q2, pc, imm, rob_id. Ready means busy && Q1==0 && Q2==0.
- Dispatch: when ena_from_dsp=1, write into the lowest-index free entry. Dispatch never arrives while full_to_if=1; if it does, it is dropped.
- Dispatch bypass: if Q1_from_dsp (or Q2) is nonzero and equals a valid CDB tag in the same cycle, store that CDB result with Q=0. The ALU CDB is checked before the LSB CDB; both CDBs never carry the same tag.
- Wake-up: for every busy entry and each valid CDB, if Qx==cdb tag (and nonzero), set Vx=result and Qx=0 at that edge. The entry becomes issue-eligible on the following edge.
- Issue: each edge, pick the lowest-index ready entry (state before this edge's updates).
  - If one exists: register its fields to the ALU outputs, assert ena_to_alu=1, and clear its busy bit. Otherwise ena_to_alu=0.
  - ena_to_alu is a one-cycle pulse per issued instruction.
- Latency: a dispatch with both operands valid at edge t issues at edge t+1, so ena_to_alu is visible in cycle t+1.
- Full: full_to_if=1 when busy count >= RS_SIZE-1. This leaves one slot of margin for the in-flight dispatch.
- Same-cycle issue and dispatch: a freed slot is reusable on the next edge, not the same edge.
- Rollback: at the edge, clear all busy bits and force ena_to_alu=0. This takes priority over dispatch, wake-up and issue. A CDB in the same cycle is ignored.
- Tag 0 never matches a CDB, even if a CDB carries tag 0.

Decomposition:
- Shared constants header: DATA_WIDTH, ROB_ID_WIDTH, OPENUM_WIDTH, RS_SIZE, openum codes, and the "tag 0 = valid" convention.
- One combinational sub-module, rs_select: a parameterised lowest-index priority encoder over a RS_SIZE-bit vector, returning index plus found flag.
  - Instantiated twice: once for the free slot, once for the ready entry.

Test Plan:
- Reset, then dispatch ADD with Q1=Q2=0, V1=5, V2=7, rob_id=3 -> next cycle ena_to_alu=1, V1=5, V2=7, rob_id_to_alu=3; the following cycle ena_to_alu=0.
- Dispatch with Q1=4, then ALU CDB tag 4, result 0x10 -> entry issues one cycle after the CDB with V1_to_alu=0x10; no earlier issue.
- Dispatch with Q2=6 in the same cycle LSB CDB broadcasts tag 6, data 0xAB -> issues next cycle with V2=0xAB.
- Fill 15 entries, all with Q1=9 -> full_to_if=1 after the 15th. Then ALU CDB tag 9 -> entries issue in index order 0..14, one per cycle, and full_to_if drops after the first issue.
- With 3 busy entries, assert rollback together with a dispatch and a CDB -> all entries cleared, ena_to_alu=0, nothing issues afterwards.
- Hold rdy=0 for 3 cycles with one ready entry -> no issue and outputs frozen; issue occurs on the first edge after rdy returns to 1.

Source files
------------

// File: rtl/reservation_station_pkg.sv
// Shared widths, operation codes and tag conventions for the integer-ALU
// reservation station.
package reservation_station_pkg;

   localparam int RS_SIZE_DEF      = 16;
   localparam int ROB_ID_WIDTH_DEF = 4;
   localparam int OPENUM_WIDTH_DEF = 6;
   localparam int DATA_WIDTH_DEF   = 32;

   // A zero tag marks an operand whose value is already present.
   localparam logic [ROB_ID_WIDTH_DEF-1:0] TAG_NONE = '0;

   typedef enum logic [OPENUM_WIDTH_DEF-1:0] {
      OP_NOP  = 6'd0,
      OP_ADD  = 6'd1,
      OP_SUB  = 6'd2,
      OP_AND  = 6'd3,
      OP_OR   = 6'd4,
      OP_XOR  = 6'd5,
      OP_SLL  = 6'd6,
      OP_SRL  = 6'd7,
      OP_SRA  = 6'd8,
      OP_SLT  = 6'd9,
      OP_SLTU = 6'd10,
      OP_LUI  = 6'd11,
      OP_BEQ  = 6'd12,
      OP_BNE  = 6'd13,
      OP_JAL  = 6'd14,
      OP_JALR = 6'd15
   } openum_e;

endpackage

// File: rtl/reservation_station_select.sv
// Lowest-index priority encoder: returns the first set bit of vec_i and
// whether any bit was set.
module rs_select #(
   parameter int N  = 16,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  vec_i,
   output logic [IW-1:0] idx_o,
   output logic          found_o
);

   always_comb begin
      idx_o   = '0;
      found_o = 1'b0;
      // Scan high to low so the lowest set bit is the last one written.
      for (int i = N - 1; i >= 0; i--) begin
         if (vec_i[i]) begin
            idx_o   = IW'(i);
            found_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/reservation_station.sv
// Integer-ALU reservation station: holds renamed ops until both operands are
// resolved from the CDBs, then issues one ready op per cycle to the ALU.
module reservation_station
   import reservation_station_pkg::*;
#(
   parameter int RS_SIZE      = RS_SIZE_DEF,
   parameter int ROB_ID_WIDTH = ROB_ID_WIDTH_DEF,
   parameter int OPENUM_WIDTH = OPENUM_WIDTH_DEF,
   parameter int DATA_WIDTH   = DATA_WIDTH_DEF
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    rdy,
   input  logic                    rollback,
   input  logic                    ena_from_dsp,
   input  logic [OPENUM_WIDTH-1:0] openum_from_dsp,
   input  logic [DATA_WIDTH-1:0]   V1_from_dsp,
   input  logic [DATA_WIDTH-1:0]   V2_from_dsp,
   input  logic [ROB_ID_WIDTH-1:0] Q1_from_dsp,
   input  logic [ROB_ID_WIDTH-1:0] Q2_from_dsp,
   input  logic [DATA_WIDTH-1:0]   pc_from_dsp,
   input  logic [DATA_WIDTH-1:0]   imm_from_dsp,
   input  logic [ROB_ID_WIDTH-1:0] rob_id_from_dsp,
   input  logic                    valid_from_rs_cdb,
   input  logic [ROB_ID_WIDTH-1:0] rob_id_from_rs_cdb,
   input  logic [DATA_WIDTH-1:0]   result_from_rs_cdb,
   input  logic                    valid_from_ls_cdb,
   input  logic [ROB_ID_WIDTH-1:0] rob_id_from_ls_cdb,
   input  logic [DATA_WIDTH-1:0]   result_from_ls_cdb,
   output logic                    full_to_if,
   output logic                    ena_to_alu,
   output logic [OPENUM_WIDTH-1:0] openum_to_alu,
   output logic [DATA_WIDTH-1:0]   V1_to_alu,
   output logic [DATA_WIDTH-1:0]   V2_to_alu,
   output logic [DATA_WIDTH-1:0]   pc_to_alu,
   output logic [DATA_WIDTH-1:0]   imm_to_alu,
   output logic [ROB_ID_WIDTH-1:0] rob_id_to_alu
);

   localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

   typedef struct packed {
      logic                    busy;
      logic [OPENUM_WIDTH-1:0] openum;
      logic [DATA_WIDTH-1:0]   v1;
      logic [DATA_WIDTH-1:0]   v2;
      logic [ROB_ID_WIDTH-1:0] q1;
      logic [ROB_ID_WIDTH-1:0] q2;
      logic [DATA_WIDTH-1:0]   pc;
      logic [DATA_WIDTH-1:0]   imm;
      logic [ROB_ID_WIDTH-1:0] rob_id;
   } entry_t;

   typedef struct packed {
      logic                    ena;
      logic [OPENUM_WIDTH-1:0] openum;
      logic [DATA_WIDTH-1:0]   v1;
      logic [DATA_WIDTH-1:0]   v2;
      logic [DATA_WIDTH-1:0]   pc;
      logic [DATA_WIDTH-1:0]   imm;
      logic [ROB_ID_WIDTH-1:0] rob_id;
   } alu_t;

   entry_t [RS_SIZE-1:0] ent_q, ent_d;
   alu_t                 alu_q, alu_d;

   logic [RS_SIZE-1:0] free_vec, ready_vec;
   logic [IDX_W-1:0]   free_idx, ready_idx;
   logic               free_found, ready_found;
   int unsigned        busy_cnt;

   function automatic logic tag_hit(input logic [ROB_ID_WIDTH-1:0] q,
                                    input logic                    v,
                                    input logic [ROB_ID_WIDTH-1:0] t);
      return v && (q != '0) && (q == t);
   endfunction

   always_comb begin
      busy_cnt = 0;
      for (int i = 0; i < RS_SIZE; i++) begin
         free_vec[i]  = ~ent_q[i].busy;
         ready_vec[i] = ent_q[i].busy && (ent_q[i].q1 == '0) && (ent_q[i].q2 == '0);
         busy_cnt     = busy_cnt + {31'd0, ent_q[i].busy};
      end
   end

   // One slot of margin absorbs a dispatch already in flight when full rises.
   assign full_to_if = (busy_cnt >= RS_SIZE - 1);

   rs_select #(.N(RS_SIZE), .IW(IDX_W)) u_free_sel (
      .vec_i   (free_vec),
      .idx_o   (free_idx),
      .found_o (free_found)
   );

   rs_select #(.N(RS_SIZE), .IW(IDX_W)) u_ready_sel (
      .vec_i   (ready_vec),
      .idx_o   (ready_idx),
      .found_o (ready_found)
   );

   always_comb begin
      ent_d     = ent_q;
      alu_d     = alu_q;
      alu_d.ena = 1'b0;
      if (rollback) begin
         for (int i = 0; i < RS_SIZE; i++) ent_d[i].busy = 1'b0;
      end else begin
         for (int i = 0; i < RS_SIZE; i++) begin
            if (ent_q[i].busy) begin
               if (tag_hit(ent_q[i].q1, valid_from_rs_cdb, rob_id_from_rs_cdb)) begin
                  ent_d[i].v1 = result_from_rs_cdb;
                  ent_d[i].q1 = '0;
               end else if (tag_hit(ent_q[i].q1, valid_from_ls_cdb, rob_id_from_ls_cdb)) begin
                  ent_d[i].v1 = result_from_ls_cdb;
                  ent_d[i].q1 = '0;
               end
               if (tag_hit(ent_q[i].q2, valid_from_rs_cdb, rob_id_from_rs_cdb)) begin
                  ent_d[i].v2 = result_from_rs_cdb;
                  ent_d[i].q2 = '0;
               end else if (tag_hit(ent_q[i].q2, valid_from_ls_cdb, rob_id_from_ls_cdb)) begin
                  ent_d[i].v2 = result_from_ls_cdb;
                  ent_d[i].q2 = '0;
               end
            end
         end

         // Issue reads pre-edge state, so a just-woken entry waits one more edge.
         if (ready_found) begin
            alu_d.ena    = 1'b1;
            alu_d.openum = ent_q[ready_idx].openum;
            alu_d.v1     = ent_q[ready_idx].v1;
            alu_d.v2     = ent_q[ready_idx].v2;
            alu_d.pc     = ent_q[ready_idx].pc;
            alu_d.imm    = ent_q[ready_idx].imm;
            alu_d.rob_id = ent_q[ready_idx].rob_id;
            ent_d[ready_idx].busy = 1'b0;
         end

         if (ena_from_dsp && free_found && !full_to_if) begin
            ent_d[free_idx].busy   = 1'b1;
            ent_d[free_idx].openum = openum_from_dsp;
            ent_d[free_idx].v1     = V1_from_dsp;
            ent_d[free_idx].v2     = V2_from_dsp;
            ent_d[free_idx].q1     = Q1_from_dsp;
            ent_d[free_idx].q2     = Q2_from_dsp;
            ent_d[free_idx].pc     = pc_from_dsp;
            ent_d[free_idx].imm    = imm_from_dsp;
            ent_d[free_idx].rob_id = rob_id_from_dsp;
            if (tag_hit(Q1_from_dsp, valid_from_rs_cdb, rob_id_from_rs_cdb)) begin
               ent_d[free_idx].v1 = result_from_rs_cdb;
               ent_d[free_idx].q1 = '0;
            end else if (tag_hit(Q1_from_dsp, valid_from_ls_cdb, rob_id_from_ls_cdb)) begin
               ent_d[free_idx].v1 = result_from_ls_cdb;
               ent_d[free_idx].q1 = '0;
            end
            if (tag_hit(Q2_from_dsp, valid_from_rs_cdb, rob_id_from_rs_cdb)) begin
               ent_d[free_idx].v2 = result_from_rs_cdb;
               ent_d[free_idx].q2 = '0;
            end else if (tag_hit(Q2_from_dsp, valid_from_ls_cdb, rob_id_from_ls_cdb)) begin
               ent_d[free_idx].v2 = result_from_ls_cdb;
               ent_d[free_idx].q2 = '0;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ent_q <= '0;
         alu_q <= '0;
      end else if (rdy) begin
         ent_q <= ent_d;
         alu_q <= alu_d;
      end
   end

   assign ena_to_alu    = alu_q.ena;
   assign openum_to_alu = alu_q.openum;
   assign V1_to_alu     = alu_q.v1;
   assign V2_to_alu     = alu_q.v2;
   assign pc_to_alu     = alu_q.pc;
   assign imm_to_alu    = alu_q.imm;
   assign rob_id_to_alu = alu_q.rob_id;

endmodule

// File: tb/tb_reservation_station.sv
// Directed bench for reservation_station: a cycle table for the basic
// issue/wake-up paths plus hand sequences for fill, rollback and rdy stall.
module tb_reservation_station;
   import reservation_station_pkg::*;

   logic        clk = 1'b0;
   logic        rst, rdy, rollback;
   logic        ena_from_dsp;
   logic [5:0]  openum_from_dsp;
   logic [31:0] V1_from_dsp, V2_from_dsp, pc_from_dsp, imm_from_dsp;
   logic [3:0]  Q1_from_dsp, Q2_from_dsp, rob_id_from_dsp;
   logic        valid_from_rs_cdb, valid_from_ls_cdb;
   logic [3:0]  rob_id_from_rs_cdb, rob_id_from_ls_cdb;
   logic [31:0] result_from_rs_cdb, result_from_ls_cdb;
   logic        full_to_if, ena_to_alu;
   logic [5:0]  openum_to_alu;
   logic [31:0] V1_to_alu, V2_to_alu, pc_to_alu, imm_to_alu;
   logic [3:0]  rob_id_to_alu;

   int tests = 0;
   int fails = 0;

   reservation_station dut (
      .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
      .ena_from_dsp(ena_from_dsp), .openum_from_dsp(openum_from_dsp),
      .V1_from_dsp(V1_from_dsp), .V2_from_dsp(V2_from_dsp),
      .Q1_from_dsp(Q1_from_dsp), .Q2_from_dsp(Q2_from_dsp),
      .pc_from_dsp(pc_from_dsp), .imm_from_dsp(imm_from_dsp),
      .rob_id_from_dsp(rob_id_from_dsp),
      .valid_from_rs_cdb(valid_from_rs_cdb), .rob_id_from_rs_cdb(rob_id_from_rs_cdb),
      .result_from_rs_cdb(result_from_rs_cdb),
      .valid_from_ls_cdb(valid_from_ls_cdb), .rob_id_from_ls_cdb(rob_id_from_ls_cdb),
      .result_from_ls_cdb(result_from_ls_cdb),
      .full_to_if(full_to_if), .ena_to_alu(ena_to_alu), .openum_to_alu(openum_to_alu),
      .V1_to_alu(V1_to_alu), .V2_to_alu(V2_to_alu), .pc_to_alu(pc_to_alu),
      .imm_to_alu(imm_to_alu), .rob_id_to_alu(rob_id_to_alu)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        dsp;
      logic [5:0]  op;
      logic [31:0] v1, v2;
      logic [3:0]  q1, q2;
      logic [31:0] pc;
      logic [3:0]  rob;
      logic        rv;
      logic [3:0]  rt;
      logic [31:0] rd;
      logic        lv;
      logic [3:0]  lt;
      logic [31:0] ld;
      logic        e_ena;
      logic [5:0]  e_op;
      logic [31:0] e_v1, e_v2, e_pc;
      logic [3:0]  e_rob;
      logic        e_full;
   } vec_t;

   vec_t tbl[14];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      ena_from_dsp = 1'b0; openum_from_dsp = '0;
      V1_from_dsp = '0; V2_from_dsp = '0; Q1_from_dsp = '0; Q2_from_dsp = '0;
      pc_from_dsp = '0; imm_from_dsp = '0; rob_id_from_dsp = '0;
      valid_from_rs_cdb = 1'b0; rob_id_from_rs_cdb = '0; result_from_rs_cdb = '0;
      valid_from_ls_cdb = 1'b0; rob_id_from_ls_cdb = '0; result_from_ls_cdb = '0;
      rollback = 1'b0;
   endtask

   task automatic dispatch(input logic [5:0] op, input logic [31:0] v1, input logic [31:0] v2,
                           input logic [3:0] q1, input logic [3:0] q2,
                           input logic [31:0] pc, input logic [3:0] rob);
      ena_from_dsp = 1'b1; openum_from_dsp = op;
      V1_from_dsp = v1; V2_from_dsp = v2; Q1_from_dsp = q1; Q2_from_dsp = q2;
      pc_from_dsp = pc; imm_from_dsp = pc + 32'h100; rob_id_from_dsp = rob;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      //          dsp op      v1     v2     q1 q2 pc       rob rv rt rd     lv lt ld     e_ena e_op    e_v1   e_v2   e_pc     e_rob full
      tbl[0]  = '{1, OP_ADD, 32'h5, 32'h7, 0, 0, 32'h1000, 3, 0, 0, 32'h0,  0, 0, 32'h0,  0, OP_NOP, 32'h0,  32'h0,  32'h0,    0, 0};
      tbl[1]  = '{0, OP_NOP, 32'h0, 32'h0, 0, 0, 32'h0,    0, 0, 0, 32'h0,  0, 0, 32'h0,  1, OP_ADD, 32'h5,  32'h7,  32'h1000, 3, 0};
      tbl[2]  = '{0, OP_NOP, 32'h0, 32'h0, 0, 0, 32'h0,    0, 0, 0, 32'h0,  0, 0, 32'h0,  0, OP_NOP, 32'h0,  32'h0,  32'h0,    0, 0};
      tbl[3]  = '{1, OP_SUB, 32'h0, 32'h2, 4, 0, 32'h1004, 5, 0, 0, 32'h0,  0, 0, 32'h0,  0, OP_NOP, 32'h0,  32'h0,  32'h0,    0, 0};
      tbl[4]  = '{0, OP_NOP, 32'h0, 32'h0, 0, 0, 32'h0,    0, 0, 0, 32'h0,  0, 0, 32'h0,  0, OP_NOP, 32'h0,  32'h0,  32'h0,    0, 0};
      tbl[5]  = '{0, OP_NOP, 32'h0, 32'h0, 0, 0, 32'h0,    0, 1, 4, 32'h10, 0, 0, 32'h0,  0, OP_NOP, 32'h0,  32'h0,  32'h0,    0, 0};
      tbl[6]  = '{0, OP_NOP, 32'h0, 32'h0, 0, 0, 32'h0,    0, 0, 0, 32'h0,  0, 0, 32'h0,  1, OP_SUB, 32'h10, 32'h2,  32'h1004, 5, 0};
      tbl[7]  = '{1, OP_ADD, 32'h1, 32'h0, 0, 6, 32'h1008, 7, 0, 0, 32'h0,  1, 6, 32'hAB, 0, OP_NOP, 32'h0,  32'h0,  32'h0,    0, 0};
      tbl[8]  = '{0, OP_NOP, 32'h0, 32'h0, 0, 0, 32'h0,    0, 0, 0, 32'h0,  0, 0, 32'h0,  1, OP_ADD, 32'h1,  32'hAB, 32'h1008, 7, 0};
      tbl[9]  = '{1, OP_XOR, 32'h22, 32'h0, 0, 3, 32'h100C, 8, 0, 0, 32'h0, 0, 0, 32'h0,  0, OP_NOP, 32'h0,  32'h0,  32'h0,    0, 0};
      tbl[10] = '{0, OP_NOP, 32'h0, 32'h0, 0, 0, 32'h0,    0, 1, 0, 32'hFF, 0, 0, 32'h0,  0, OP_NOP, 32'h0,  32'h0,  32'h0,    0, 0};
      tbl[11] = '{0, OP_NOP, 32'h0, 32'h0, 0, 0, 32'h0,    0, 0, 0, 32'h0,  1, 3, 32'h44, 0, OP_NOP, 32'h0,  32'h0,  32'h0,    0, 0};
      tbl[12] = '{0, OP_NOP, 32'h0, 32'h0, 0, 0, 32'h0,    0, 0, 0, 32'h0,  0, 0, 32'h0,  1, OP_XOR, 32'h22, 32'h44, 32'h100C, 8, 0};
      tbl[13] = '{0, OP_NOP, 32'h0, 32'h0, 0, 0, 32'h0,    0, 0, 0, 32'h0,  0, 0, 32'h0,  0, OP_NOP, 32'h0,  32'h0,  32'h0,    0, 0};

      idle_inputs();
      rdy = 1'b1;
      rst = 1'b1;
      step(); step();
      chk("reset ena", {31'd0, ena_to_alu}, 32'd0);
      chk("reset full", {31'd0, full_to_if}, 32'd0);
      chk("reset V1", V1_to_alu, 32'd0);
      chk("reset rob", {28'd0, rob_id_to_alu}, 32'd0);
      rst = 1'b0;

      for (int i = 0; i < 14; i++) begin
         idle_inputs();
         if (tbl[i].dsp)
            dispatch(tbl[i].op, tbl[i].v1, tbl[i].v2, tbl[i].q1, tbl[i].q2, tbl[i].pc, tbl[i].rob);
         valid_from_rs_cdb = tbl[i].rv; rob_id_from_rs_cdb = tbl[i].rt; result_from_rs_cdb = tbl[i].rd;
         valid_from_ls_cdb = tbl[i].lv; rob_id_from_ls_cdb = tbl[i].lt; result_from_ls_cdb = tbl[i].ld;
         step();
         chk($sformatf("vec%0d ena", i), {31'd0, ena_to_alu}, {31'd0, tbl[i].e_ena});
         chk($sformatf("vec%0d full", i), {31'd0, full_to_if}, {31'd0, tbl[i].e_full});
         if (tbl[i].e_ena) begin
            chk($sformatf("vec%0d op", i), {26'd0, openum_to_alu}, {26'd0, tbl[i].e_op});
            chk($sformatf("vec%0d V1", i), V1_to_alu, tbl[i].e_v1);
            chk($sformatf("vec%0d V2", i), V2_to_alu, tbl[i].e_v2);
            chk($sformatf("vec%0d pc", i), pc_to_alu, tbl[i].e_pc);
            chk($sformatf("vec%0d imm", i), imm_to_alu, tbl[i].e_pc + 32'h100);
            chk($sformatf("vec%0d rob", i), {28'd0, rob_id_to_alu}, {28'd0, tbl[i].e_rob});
         end
      end

      // Reset after outputs carry data must zero them.
      idle_inputs();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("rst2 V1", V1_to_alu, 32'd0);
      chk("rst2 pc", pc_to_alu, 32'd0);
      chk("rst2 op", {26'd0, openum_to_alu}, 32'd0);

      // Fill 15 entries waiting on tag 9, one extra dispatch while full is dropped.
      for (int i = 0; i < 15; i++) begin
         idle_inputs();
         dispatch(OP_ADD, 32'h0, 32'h0, 4'd9, 4'd0, 32'h2000 + 32'(i * 4), 4'(i + 1));
         step();
         chk($sformatf("fill%0d full", i), {31'd0, full_to_if}, (i == 14) ? 32'd1 : 32'd0);
         chk($sformatf("fill%0d ena", i), {31'd0, ena_to_alu}, 32'd0);
      end
      idle_inputs();
      dispatch(OP_SUB, 32'hDEAD, 32'h0, 4'd9, 4'd0, 32'h3000, 4'd0);
      step();
      chk("drop full", {31'd0, full_to_if}, 32'd1);
      idle_inputs();
      valid_from_rs_cdb = 1'b1; rob_id_from_rs_cdb = 4'd9; result_from_rs_cdb = 32'h99;
      step();
      chk("wake ena", {31'd0, ena_to_alu}, 32'd0);
      idle_inputs();
      for (int k = 0; k < 15; k++) begin
         step();
         chk($sformatf("drain%0d ena", k), {31'd0, ena_to_alu}, 32'd1);
         chk($sformatf("drain%0d rob", k), {28'd0, rob_id_to_alu}, 32'(k + 1));
         chk($sformatf("drain%0d V1", k), V1_to_alu, 32'h99);
         chk($sformatf("drain%0d pc", k), pc_to_alu, 32'h2000 + 32'(k * 4));
         if (k == 0) chk("drain0 full", {31'd0, full_to_if}, 32'd0);
      end
      step();
      chk("drain end ena", {31'd0, ena_to_alu}, 32'd0);

      // Rollback with a ready entry, a ready dispatch and a waking CDB in flight.
      idle_inputs(); dispatch(OP_ADD, 32'h0, 32'h1, 4'd5, 4'd0, 32'h4000, 4'd1); step();
      idle_inputs(); dispatch(OP_ADD, 32'h0, 32'h2, 4'd5, 4'd0, 32'h4004, 4'd2); step();
      idle_inputs(); dispatch(OP_ADD, 32'h3, 32'h3, 4'd0, 4'd0, 32'h4008, 4'd3); step();
      idle_inputs();
      dispatch(OP_ADD, 32'h4, 32'h4, 4'd0, 4'd0, 32'h400C, 4'd4);
      valid_from_rs_cdb = 1'b1; rob_id_from_rs_cdb = 4'd5; result_from_rs_cdb = 32'h77;
      rollback = 1'b1;
      step();
      chk("rollback ena", {31'd0, ena_to_alu}, 32'd0);
      idle_inputs();
      for (int k = 0; k < 3; k++) begin
         step();
         chk($sformatf("post-rollback%0d ena", k), {31'd0, ena_to_alu}, 32'd0);
      end

      // rdy low freezes an issued output and blocks the next ready entry.
      idle_inputs(); dispatch(OP_OR, 32'h55, 32'h0, 4'd0, 4'd0, 32'h5000, 4'd2); step();
      idle_inputs(); dispatch(OP_OR, 32'h66, 32'h0, 4'd0, 4'd0, 32'h5004, 4'd3); step();
      chk("pre-stall ena", {31'd0, ena_to_alu}, 32'd1);
      chk("pre-stall V1", V1_to_alu, 32'h55);
      idle_inputs();
      dispatch(OP_AND, 32'h88, 32'h0, 4'd0, 4'd0, 32'h5008, 4'd9);
      rdy = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step();
         chk($sformatf("stall%0d ena", k), {31'd0, ena_to_alu}, 32'd1);
         chk($sformatf("stall%0d V1", k), V1_to_alu, 32'h55);
         chk($sformatf("stall%0d rob", k), {28'd0, rob_id_to_alu}, 32'd2);
      end
      idle_inputs();
      rdy = 1'b1;
      step();
      chk("resume ena", {31'd0, ena_to_alu}, 32'd1);
      chk("resume V1", V1_to_alu, 32'h66);
      chk("resume rob", {28'd0, rob_id_to_alu}, 32'd3);
      step();
      chk("resume end ena", {31'd0, ena_to_alu}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
